alu_issue_stage: RTL

- Registered issue/capture stage wrapped around the 16-bit combinational ALU (operand ports M, N, carry C, 3-bit opcode; result F, flags zer/neg).
- Accepts commands over a valid/ready handshake and holds them in an operand register that drives the ALU.
- Captures the ALU result and flags one cycle later into a small result FIFO, then returns them over a second valid/ready handshake.
- Each command gets a wrapping sequence tag, and the stage keeps sticky status counters.

---
 rtl/alu_issue_pkg.sv | 23 ++
 rtl/alu_res_fifo.sv | 62 ++++++
 rtl/alu_issue_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
// Shared definitions for the ALU issue/capture stage: opcode constants for the
// attached 16-bit ALU and the result-FIFO entry layout.
// RES_W / RES_TAG_W fix the entry layout; the stage's WIDTH / TAG_W parameters
// must equal them.
package alu_issue_pkg;

    localparam int RES_W     = 16;
    localparam int RES_TAG_W = 4;

    localparam logic [2:0] OPC_ADD = 3'b100;
    localparam logic [2:0] OPC_AND = 3'b001;
    localparam logic [2:0] OPC_INC = 3'b010;
    localparam logic [2:0] OPC_OR  = 3'b111;

    typedef struct packed {
        logic [RES_W-1:0]     f;
        logic                 zer;
        logic                 neg;
        logic [RES_TAG_W-1:0] tag;
    } res_entry_t;

endpackage

// File: rtl/alu_res_fifo.sv
// alu_res_fifo
// Synchronous FIFO of res_entry_t used to queue captured ALU results.
// Ports:
//   clk, rst_n      clock, async active-low reset (storage cleared too, so the
//                   head reads zero while empty after reset)
//   push, push_d    write request and entry
//   pop             read request (head advances)
//   head            current head entry (valid when !empty)
//   full, empty     status
// A push while full is accepted only if a pop happens in the same cycle.
module alu_res_fifo
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  res_entry_t push_d,
    input  logic       pop,
    output res_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    res_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_d;
                wr_ptr      <= wr_ptr + AW'(1);  // power-of-two depth wraps naturally
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Registered issue/capture stage around a combinational 16-bit ALU.
// Ports:
//   cmd_valid/cmd_ready, cmd_m/n/c/opc   command handshake and operands
//   alu_m/n/c/opc                        registered operands driving the ALU
//   alu_f, alu_zer, alu_neg              ALU result and flags
//   res_valid/res_ready, res_f/zer/neg/tag  result handshake from FIFO head
//   busy                                 operand register or FIFO occupied
//   op_count, zero_count                 saturating capture counters
// A command accepted at edge k is captured into the FIFO at edge k+1, giving one
// cycle of latency with no combinational path from cmd_* to res_*.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int WIDTH = RES_W,
    parameter int DEPTH = 4,
    parameter int TAG_W = RES_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_m,
    input  logic [WIDTH-1:0] cmd_n,
    input  logic             cmd_c,
    input  logic [2:0]       cmd_opc,
    output logic [WIDTH-1:0] alu_m,
    output logic [WIDTH-1:0] alu_n,
    output logic             alu_c,
    output logic [2:0]       alu_opc,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_zer,
    input  logic             alu_neg,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_f,
    output logic             res_zer,
    output logic             res_neg,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy,
    output logic [15:0]      op_count,
    output logic [15:0]      zero_count
);

    logic             s1_valid;
    logic [TAG_W-1:0] s1_tag;
    logic [TAG_W-1:0] tag_cnt;
    logic             rdy_en;     // holds cmd_ready low until the first edge out of reset
    logic             fifo_full;
    logic             fifo_empty;
    logic             capture;
    logic             pop;
    logic             accept;
    res_entry_t       push_d;
    res_entry_t       head;

    assign pop       = res_valid && res_ready;
    // A same-cycle pop frees a slot, so capture still proceeds into a full FIFO.
    assign capture   = s1_valid && (!fifo_full || pop);
    assign cmd_ready = rdy_en && (!s1_valid || capture);
    assign accept    = cmd_valid && cmd_ready;

    assign push_d = '{f: alu_f, zer: alu_zer, neg: alu_neg, tag: s1_tag};

    alu_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (capture),
        .push_d (push_d),
        .pop    (pop),
        .head   (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign res_valid = !fifo_empty;
    assign res_f     = head.f;
    assign res_zer   = head.zer;
    assign res_neg   = head.neg;
    assign res_tag   = head.tag;
    assign busy      = s1_valid || !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en     <= 1'b0;
            s1_valid   <= 1'b0;
            s1_tag     <= '0;
            tag_cnt    <= '0;
            alu_m      <= '0;
            alu_n      <= '0;
            alu_c      <= 1'b0;
            alu_opc    <= '0;
            op_count   <= '0;
            zero_count <= '0;
        end else begin
            rdy_en <= 1'b1;
            // Operands are only ever overwritten by a new accept; they stay
            // stable while stalled so the ALU output is re-sampled at capture.
            if (accept) begin
                alu_m    <= cmd_m;
                alu_n    <= cmd_n;
                alu_c    <= cmd_c;
                alu_opc  <= cmd_opc;
                s1_tag   <= tag_cnt;
                tag_cnt  <= tag_cnt + TAG_W'(1);
                s1_valid <= 1'b1;
            end else if (capture) begin
                s1_valid <= 1'b0;
            end
            if (capture) begin
                if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
                if (alu_zer && zero_count != 16'hFFFF) zero_count <= zero_count + 16'd1;
            end
        end
    end

endmodule
